// File: rtl/dat31_pkg.sv
// Shared types and helpers for the DAT-31R5-SP attenuator bus scheduler.
package dat31_pkg;

    localparam int unsigned ATT_BITS     = 6;
    localparam int unsigned FRAME_HALVES = 15;
    localparam int unsigned MAX_CH       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD,
        ST_LATCH,
        ST_GAP
    } state_e;

    // First set request at or after ptr+1 (mod nch); returns {found, index}.
    function automatic logic [3:0] rr_search(input logic [MAX_CH-1:0] req,
                                             input logic [2:0]        ptr,
                                             input int unsigned       nch);
        logic [3:0]  res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = (32'(ptr) + k) % nch;
            if ((k <= nch) && !res[3] && req[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dat31_rr_arb.sv
// Combinational round-robin arbiter; the last-grant pointer lives in the parent.
module dat31_rr_arb
    import dat31_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CHW-1:0] idx_o,
    output logic           valid_o
);

    logic [3:0] res;

    always_comb begin
        res     = rr_search(MAX_CH'(req_i), 3'(ptr_i), NCH);
        valid_o = res[3];
        idx_o   = CHW'(res[2:0]);
        gnt_o   = res[3] ? (NCH'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/dat31_scheduler.sv
// Round-robin writer sharing one serial bus among NCH DAT-31R5-SP attenuators.
module dat31_scheduler
    import dat31_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned HALF_DIV = 1,
    parameter int unsigned CHW      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ATT_BITS*NCH-1:0] setting_flat,
    input  logic [NCH-1:0]          force_wr,
    output logic                    att_clk,
    output logic                    att_data,
    output logic [NCH-1:0]          att_le,
    output logic                    busy,
    output logic [CHW-1:0]          active_ch,
    output logic                    frame_done,
    output logic [ATT_BITS*NCH-1:0] written_flat
);

    localparam int unsigned CNTW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned SW   = ATT_BITS * NCH;

    state_e                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [ATT_BITS-1:0]   shadow_q, shadow_d;
    logic [CHW-1:0]        ptr_q, ptr_d;
    logic [CHW-1:0]        active_q, active_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aclk_q, aclk_d;
    logic                  adata_q, adata_d;
    logic [NCH-1:0]        le_q, le_d;
    logic [SW-1:0]         written_q, written_d;
    logic [NCH-1:0]        force_q, force_d;

    logic [NCH-1:0]        pending;
    logic [NCH-1:0]        gnt;
    logic [CHW-1:0]        gnt_idx;
    logic                  gnt_vld;
    logic [NCH-1:0]        clr;
    logic                  last;

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            pending[i] = (setting_flat[ATT_BITS*i +: ATT_BITS] != written_q[ATT_BITS*i +: ATT_BITS])
                         | force_q[i];
        end
    end

    dat31_rr_arb #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req_i   (pending),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    // Next-state logic; bus pins are derived from the next state so they register in step with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shadow_d  = shadow_q;
        ptr_d     = ptr_q;
        active_d  = active_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        written_d = written_q;
        clr       = '0;
        last      = (cnt_q == CNTW'(HALF_DIV - 1));

        if (state_q != ST_IDLE) begin
            cnt_d = last ? '0 : cnt_q + CNTW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (gnt_vld) begin
                    shadow_d = setting_flat[ATT_BITS*int'(gnt_idx) +: ATT_BITS];
                    active_d = gnt_idx;
                    ptr_d    = gnt_idx;
                    busy_d   = 1'b1;
                    bit_d    = 3'(ATT_BITS - 1);
                    clr      = gnt;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: if (last) state_d = ST_HIGH;
            ST_HIGH: begin
                if (last) begin
                    if (bit_q == 3'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_HOLD: if (last) state_d = ST_LATCH;
            ST_LATCH: begin
                if (last) begin
                    written_d[ATT_BITS*int'(active_q) +: ATT_BITS] = shadow_q;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        aclk_d  = (state_d == ST_HIGH);
        adata_d = (state_d == ST_SETUP || state_d == ST_HIGH || state_d == ST_HOLD)
                  ? shadow_d[bit_d] : 1'b0;
        le_d    = (state_d == ST_LATCH) ? (NCH'(1) << active_d) : '0;
        // A force pulse arriving in the grant cycle must survive the clear.
        force_d = (force_q & ~clr) | force_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shadow_q  <= '0;
            ptr_q     <= CHW'(NCH - 1);
            active_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aclk_q    <= 1'b0;
            adata_q   <= 1'b0;
            le_q      <= '0;
            written_q <= '0;
            force_q   <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shadow_q  <= shadow_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aclk_q    <= aclk_d;
            adata_q   <= adata_d;
            le_q      <= le_d;
            written_q <= written_d;
            force_q   <= force_d;
        end
    end

    assign att_clk      = aclk_q;
    assign att_data     = adata_q;
    assign att_le       = le_q;
    assign busy         = busy_q;
    assign active_ch    = active_q;
    assign frame_done   = done_q;
    assign written_flat = written_q;

endmodule
